// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch-stage PC generator.
// Next-PC select codes, redirect latch states, default vectors.
package pc_gen_pkg;

   localparam logic [2:0] NPC_ADD4    = 3'd0;
   localparam logic [2:0] NPC_J       = 3'd1;
   localparam logic [2:0] NPC_JR      = 3'd2;
   localparam logic [2:0] NPC_BGEZALR = 3'd3;
   localparam logic [2:0] NPC_BRANCH  = 3'd4;

   typedef enum logic {
      PCG_IDLE = 1'b0,
      PCG_PEND = 1'b1
   } pcg_state_e;

   localparam logic [31:0] PCG_RESET_VECTOR = 32'h0000_3000;
   localparam logic [31:0] PCG_EXC_VECTOR   = 32'h0000_4180;
   localparam logic [31:0] PCG_IMEM_BASE    = 32'h0000_3000;
   localparam logic [31:0] PCG_IMEM_LIMIT   = 32'h0000_6FFC;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that arrived while fetch was stalled.
// Ports: Clk, Reset, redirect_valid/target, En, clear -> pending, target.
module pc_redirect_latch
   import pc_gen_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             En,
   input  logic             clear,
   output logic             pending,
   output logic [WIDTH-1:0] target
);

   pcg_state_e       state_q = PCG_IDLE;
   pcg_state_e       state_d;
   logic [WIDTH-1:0] target_q = '0;
   logic [WIDTH-1:0] target_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= PCG_IDLE;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   // A redirect seen while stalled is latched; a newer one
   // overwrites it. Exception/eret (clear) discard it.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      if (clear) begin
         state_d = PCG_IDLE;
      end else if (redirect_valid) begin
         if (En) begin
            state_d = PCG_IDLE;
         end else begin
            state_d  = PCG_PEND;
            target_d = redirect_target;
         end
      end else if (state_q == PCG_PEND && En) begin
         state_d = PCG_IDLE;
      end
   end

   assign pending = (state_q == PCG_PEND);
   assign target  = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter and next-PC selection.
// Ports: Clk, Reset, En, PCsrc, Branch, NPC, j_r1, j_r2,
//   redirect_valid/target, exc_req, eret_req, epc ->
//   PC, PC_plus4, fetch_exc, redirect_pending, fetch_cnt.
// Macro PC_FETCH_CNT_EN enables the fetch_cnt counter.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR =
      WIDTH'(PCG_RESET_VECTOR),
   parameter logic [WIDTH-1:0] EXC_VECTOR =
      WIDTH'(PCG_EXC_VECTOR),
   parameter logic [WIDTH-1:0] IMEM_BASE =
      WIDTH'(PCG_IMEM_BASE),
   parameter logic [WIDTH-1:0] IMEM_LIMIT =
      WIDTH'(PCG_IMEM_LIMIT)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic [2:0]       PCsrc,
   input  logic             Branch,
   input  logic [WIDTH-1:0] NPC,
   input  logic [WIDTH-1:0] j_r1,
   input  logic [WIDTH-1:0] j_r2,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_plus4,
   output logic             fetch_exc,
   output logic             redirect_pending,
   output logic [31:0]      fetch_cnt
);

   logic [WIDTH-1:0] pc_q = RESET_VECTOR;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] sel_pc;
   logic [WIDTH-1:0] pend_target;
   logic             pend;
   logic             clear;

   assign clear = exc_req | eret_req;

   pc_redirect_latch #(
      .WIDTH(WIDTH)
   ) u_latch (
      .Clk             (Clk),
      .Reset           (Reset),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .En              (En),
      .clear           (clear),
      .pending         (pend),
      .target          (pend_target)
   );

   assign PC_plus4 = pc_q + WIDTH'(4);

   always_comb begin
      sel_pc = PC_plus4;
      unique case (PCsrc)
         NPC_J:       sel_pc = NPC;
         NPC_JR:      sel_pc = j_r1;
         NPC_BGEZALR: sel_pc = Branch ? j_r2 : PC_plus4;
         NPC_BRANCH:  sel_pc = Branch ? NPC : PC_plus4;
         default:     sel_pc = PC_plus4;
      endcase
   end

   // Exception and eret override stall; a redirect under
   // stall holds PC and is applied from the latch later.
   always_comb begin
      pc_d = pc_q;
      if (exc_req) begin
         pc_d = EXC_VECTOR;
      end else if (eret_req) begin
         pc_d = epc;
      end else if (redirect_valid) begin
         if (En) begin
            pc_d = redirect_target;
         end
      end else if (pend && En) begin
         pc_d = pend_target;
      end else if (En) begin
         pc_d = sel_pc;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PC               = pc_q;
   assign redirect_pending = pend;

   assign fetch_exc = (pc_q[1:0] != 2'b00)
                    | (pc_q < IMEM_BASE)
                    | (pc_q > IMEM_LIMIT);

`ifdef PC_FETCH_CNT_EN
   logic [31:0] cnt_q = '0;
   logic        cnt_inc;

   // With En=1 every edge loads PC; exc/eret load regardless.
   assign cnt_inc = En | exc_req | eret_req;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else if (cnt_inc) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = cnt_q;
`else
   assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen with a reference model.
// Directed scenarios followed by randomized stimulus.
module tb_pc_gen;

   localparam logic [31:0] RV    = 32'h0000_3000;
   localparam logic [31:0] EV    = 32'h0000_4180;
   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam logic [31:0] LIMIT = 32'h0000_6FFC;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        En = 1'b0;
   logic [2:0]  PCsrc = 3'd0;
   logic        Branch = 1'b0;
   logic [31:0] NPC = '0;
   logic [31:0] j_r1 = '0;
   logic [31:0] j_r2 = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] PC;
   logic [31:0] PC_plus4;
   logic        fetch_exc;
   logic        redirect_pending;
   logic [31:0] fetch_cnt;

   int errors = 0;
   int checks = 0;

   longint unsigned m_pc;
   bit              m_pend;
   longint unsigned m_ptgt;
   longint unsigned m_cnt;

   pc_gen dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .En              (En),
      .PCsrc           (PCsrc),
      .Branch          (Branch),
      .NPC             (NPC),
      .j_r1            (j_r1),
      .j_r2            (j_r2),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .exc_req         (exc_req),
      .eret_req        (eret_req),
      .epc             (epc),
      .PC              (PC),
      .PC_plus4        (PC_plus4),
      .fetch_exc       (fetch_exc),
      .redirect_pending(redirect_pending),
      .fetch_cnt       (fetch_cnt)
   );

   always #5 Clk = ~Clk;

   function automatic longint unsigned pick(
      longint unsigned pc);
      longint unsigned nxt;
      nxt = (pc + 4) % (64'd1 << 32);
      case (PCsrc)
         3'd1: return NPC;
         3'd2: return j_r1;
         3'd3: return Branch ? j_r2 : nxt;
         3'd4: return Branch ? NPC : nxt;
         default: return nxt;
      endcase
   endfunction

   function automatic bit exp_exc(longint unsigned pc);
      return (pc % 4 != 0) || (pc < BASE) || (pc > LIMIT);
   endfunction

   function automatic logic [31:0] exp_cnt();
`ifdef PC_FETCH_CNT_EN
      return m_cnt[31:0];
`else
      return 32'd0;
`endif
   endfunction

   // One clock edge: model follows the same inputs, pulse
   // inputs are dropped afterwards.
   task automatic cycle();
      if (Reset) begin
         m_pc = RV; m_pend = 0; m_cnt = 0;
      end else if (exc_req) begin
         m_pc = EV; m_pend = 0; m_cnt++;
      end else if (eret_req) begin
         m_pc = epc; m_pend = 0; m_cnt++;
      end else if (redirect_valid && En) begin
         m_pc = redirect_target; m_pend = 0; m_cnt++;
      end else if (redirect_valid) begin
         m_pend = 1; m_ptgt = redirect_target;
      end else if (m_pend && En) begin
         m_pc = m_ptgt; m_pend = 0; m_cnt++;
      end else if (En) begin
         m_pc = pick(m_pc); m_cnt++;
      end
      m_cnt = m_cnt % (64'd1 << 32);
      @(posedge Clk);
      #1;
      Reset = 0;
      redirect_valid = 0;
      exc_req = 0;
      eret_req = 0;
   endtask

   task automatic test_reset();
      Reset = 1;
      En = 1;
      cycle();
      checks++;
      if (PC !== RV) begin
         errors++;
         $display("FAIL reset_pc: got %h expected %h", PC, RV);
      end
      checks++;
      if (redirect_pending !== 1'b0 || fetch_exc !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b%b expected 00",
                  redirect_pending, fetch_exc);
      end
      checks++;
      if (fetch_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %h expected 0", fetch_cnt);
      end
   endtask

   task automatic test_add4();
      En = 1;
      PCsrc = 3'd0;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         checks++;
         if (PC !== RV + 32'(4 * i) || fetch_exc !== 1'b0) begin
            errors++;
            $display("FAIL add4_%0d: got %h/%b expected %h/0",
                     i, PC, fetch_exc, RV + 32'(4 * i));
         end
      end
   endtask

   task automatic test_branch();
      cycle();
      PCsrc = 3'd4; Branch = 1; NPC = 32'h3100;
      cycle();
      checks++;
      if (PC !== 32'h3100) begin
         errors++;
         $display("FAIL branch_taken: got %h expected 3100", PC);
      end
      PCsrc = 3'd1; NPC = 32'h3010;
      cycle();
      PCsrc = 3'd4; Branch = 0; NPC = 32'h3100;
      cycle();
      checks++;
      if (PC !== 32'h3014) begin
         errors++;
         $display("FAIL branch_not: got %h expected 3014", PC);
      end
      PCsrc = 3'd3; Branch = 1; j_r2 = 32'h3800;
      cycle();
      checks++;
      if (PC !== 32'h3800) begin
         errors++;
         $display("FAIL bgezalr: got %h expected 3800", PC);
      end
      PCsrc = 3'd7;
      cycle();
      checks++;
      if (PC !== 32'h3804) begin
         errors++;
         $display("FAIL src_other: got %h expected 3804", PC);
      end
   endtask

   task automatic test_redirect_stall();
      logic [31:0] held;
      held = PC;
      En = 0; PCsrc = 3'd0;
      redirect_valid = 1; redirect_target = 32'h3400;
      cycle();
      checks++;
      if (PC !== held || redirect_pending !== 1'b1) begin
         errors++;
         $display("FAIL redir_latch: got %h/%b expected %h/1",
                  PC, redirect_pending, held);
      end
      cycle();
      cycle();
      checks++;
      if (PC !== held || redirect_pending !== 1'b1) begin
         errors++;
         $display("FAIL redir_hold: got %h/%b expected %h/1",
                  PC, redirect_pending, held);
      end
      En = 1;
      cycle();
      checks++;
      if (PC !== 32'h3400 || redirect_pending !== 1'b0) begin
         errors++;
         $display("FAIL redir_apply: got %h/%b expected 3400/0",
                  PC, redirect_pending);
      end
      En = 0;
      redirect_valid = 1; redirect_target = 32'h3500;
      cycle();
      redirect_valid = 1; redirect_target = 32'h3600;
      cycle();
      En = 1;
      cycle();
      checks++;
      if (PC !== 32'h3600) begin
         errors++;
         $display("FAIL redir_newest: got %h expected 3600", PC);
      end
      redirect_valid = 1; redirect_target = 32'h3700;
      cycle();
      checks++;
      if (PC !== 32'h3700 || redirect_pending !== 1'b0) begin
         errors++;
         $display("FAIL redir_direct: got %h/%b expected 3700/0",
                  PC, redirect_pending);
      end
   endtask

   task automatic test_exc_eret();
      En = 0;
      redirect_valid = 1; redirect_target = 32'h3400;
      cycle();
      exc_req = 1;
      cycle();
      checks++;
      if (PC !== EV || redirect_pending !== 1'b0) begin
         errors++;
         $display("FAIL exc_entry: got %h/%b expected %h/0",
                  PC, redirect_pending, EV);
      end
      eret_req = 1; epc = 32'h3204;
      cycle();
      checks++;
      if (PC !== 32'h3204) begin
         errors++;
         $display("FAIL eret: got %h expected 3204", PC);
      end
      exc_req = 1; eret_req = 1;
      cycle();
      checks++;
      if (PC !== EV) begin
         errors++;
         $display("FAIL exc_over_eret: got %h expected %h", PC, EV);
      end
      En = 1;
      cycle();
      checks++;
      if (PC !== EV + 32'd4) begin
         errors++;
         $display("FAIL exc_then_add4: got %h expected %h",
                  PC, EV + 32'd4);
      end
   endtask

   task automatic test_fetch_exc();
      logic [31:0] addr [6];
      logic        expb [6];
      addr = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC,
               32'h3000, 32'h6FFD};
      expb = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      En = 1; PCsrc = 3'd2;
      for (int i = 0; i < 6; i++) begin
         j_r1 = addr[i];
         cycle();
         checks++;
         if (PC !== addr[i] || fetch_exc !== expb[i]) begin
            errors++;
            $display("FAIL fexc_%0d: got %h/%b expected %h/%b",
                     i, PC, fetch_exc, addr[i], expb[i]);
         end
      end
      j_r1 = 32'hFFFF_FFFC;
      cycle();
      checks++;
      if (PC_plus4 !== 32'd0 || fetch_exc !== 1'b1) begin
         errors++;
         $display("FAIL wrap: got %h/%b expected 0/1",
                  PC_plus4, fetch_exc);
      end
      PCsrc = 3'd0;
      cycle();
      checks++;
      if (PC !== 32'd0) begin
         errors++;
         $display("FAIL wrap_pc: got %h expected 0", PC);
      end
   endtask

   task automatic test_cnt();
      Reset = 1;
      cycle();
      PCsrc = 3'd0;
      for (int i = 0; i < 7; i++) begin
         En = (i == 2 || i == 4) ? 1'b0 : 1'b1;
         cycle();
      end
      checks++;
`ifdef PC_FETCH_CNT_EN
      if (fetch_cnt !== 32'd5) begin
         errors++;
         $display("FAIL cnt_five: got %0d expected 5", fetch_cnt);
      end
`else
      if (fetch_cnt !== 32'd0) begin
         errors++;
         $display("FAIL cnt_off: got %0d expected 0", fetch_cnt);
      end
`endif
      Reset = 1;
      cycle();
      checks++;
      if (fetch_cnt !== 32'd0 || PC !== RV) begin
         errors++;
         $display("FAIL cnt_reset: got %0d/%h expected 0/%h",
                  fetch_cnt, PC, RV);
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return BASE + 32'($urandom_range(0, 'h3FFF) * 4);
   endfunction

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         Reset           = ($urandom_range(0, 99) == 0);
         En              = ($urandom_range(0, 2) != 0);
         PCsrc           = 3'($urandom_range(0, 7));
         Branch          = 1'($urandom);
         NPC             = rnd_addr();
         j_r1            = rnd_addr();
         j_r2            = rnd_addr();
         epc             = rnd_addr();
         redirect_target = rnd_addr();
         redirect_valid  = ($urandom_range(0, 5) == 0);
         exc_req         = ($urandom_range(0, 19) == 0);
         eret_req        = ($urandom_range(0, 19) == 0);
         cycle();
         checks++;
         if (PC !== m_pc[31:0]
             || PC_plus4 !== 32'(m_pc + 4)
             || fetch_exc !== exp_exc(m_pc)
             || redirect_pending !== m_pend
             || fetch_cnt !== exp_cnt()) begin
            errors++;
            $display("FAIL rand_%0d: got %h %h %b %b %h expected %h %h %b %b %h",
                     i, PC, PC_plus4, fetch_exc, redirect_pending,
                     fetch_cnt, m_pc[31:0], 32'(m_pc + 4),
                     exp_exc(m_pc), m_pend, exp_cnt());
         end
      end
   endtask

   initial begin
      m_pc = RV; m_pend = 0; m_ptgt = 0; m_cnt = 0;
      #1;
      test_reset();
      test_add4();
      test_branch();
      test_redirect_stall();
      test_exc_eret();
      test_fetch_exc();
      test_cnt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
